nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle WIDTH-bit adder controller built around one `CLA_4_bit` slice (ports a, b, c_in, sum, c_out). Accepts a full-width operand pair through a valid/ready handshake. Steps the slice across the operands one nibble per clock, least significant first, registering each nibble sum and feeding the slice carry-out back as the next carry-in. Presents the registered result with a valid/ready handshake to the downstream consumer. Sits directly upstream of the 4-bit CLA: it sequences and feeds the slice and collects what it produces.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4, minimum 4
- NIB (localparam), WIDTH/4, nibble count
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous and active-high
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry into bit 0
- sub  input  1  subtract request; present only with SUBTRACT_EN
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered result
- c_out  output  1  carry out of MSB
- ovf  output  1  signed overflow of the WIDTH-bit operation
- busy  output  1  high in RUN

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `in_valid && in_ready`.
  - RUN → DONE when the nibble index equals NIB-1.
  - DONE → IDLE on `out_valid && out_ready`.
- Outputs by state:
  - `in_ready = (state==IDLE)`.
  - `busy = (state==RUN)`.
  - `out_valid = (state==DONE)`.
- Accept:
  - Latch a, b (or ~b, see Configuration) and c_in into internal operand registers.
  - Carry register <= c_in; nibble index <= 0; sum register <= 0.
- RUN cycle, with index i:
  - Slice inputs are operand nibbles [4i+3:4i] and the carry register.
  - At the clock edge: sum[4i+3:4i] <= slice sum; carry register <= slice c_out; index <= i+1.
- Final nibble (i = NIB-1):
  - c_out <= slice c_out.
  - ovf <= (A[MSB] == Beff[MSB]) && (slice sum bit 3 != A[MSB]), where Beff is the latched (possibly inverted) B.
- Width rule: the result is modulo 2^WIDTH; the carry beyond the MSB appears only on c_out.
- Inputs a, b, c_in and sub are sampled only at accept. Changes during RUN or DONE are ignored.
- sum, c_out and ovf hold stable throughout DONE until the output handshake completes, even if out_ready stays low indefinitely.
- The block never accepts new operands while in RUN or DONE. A new accept is possible in the cycle after the output handshake.

## Timing
- Reset values:
  - state IDLE, index 0, carry register 0.
  - sum 0, c_out 0, ovf 0, out_valid 0, busy 0, in_ready 1.
- Reset asserted mid-RUN or in DONE: all registers return to their reset values immediately (asynchronously). The in-flight result is discarded with no partial out_valid.
- Latency: accept at edge k. RUN occupies cycles k+1 … k+NIB. out_valid rises after edge k+NIB. With WIDTH=16, out_valid goes high 4 cycles after the accept edge.
- Throughput: with out_ready held high, one result every NIB+2 cycles.
- Simultaneous in_valid while out_valid is high: ignored, because in_ready is 0.

## Configuration
- SUBTRACT_EN defined:
  - The sub port exists.
  - At accept, if sub=1, the operand register latches ~b and the carry register latches 1, ignoring c_in. The block computes A−B.
  - c_out=1 means no borrow. ovf is signed subtraction overflow.
- SUBTRACT_EN undefined:
  - The sub port is absent.
  - The block performs addition only with the given c_in.

## Test plan
- Plain add, WIDTH=16: a=0x1234, b=0x4321, c_in=0 → after 4 cycles out_valid=1, sum=0x5555, c_out=0, ovf=0.
- Full carry ripple: a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1, ovf=0; the carry propagates through all four nibbles.
- Signed overflow: a=0x7FFF, b=0x0001, c_in=1 → sum=0x8001, c_out=0, ovf=1.
- Backpressure: out_ready held low 5 cycles after out_valid, in_valid pulsed with new operands meanwhile → sum, c_out and ovf are unchanged and in_ready=0. After out_ready=1, the result is consumed, in_ready=1 next cycle, and the next operands are accepted.
- Reset mid-op: rst asserted during the 2nd RUN cycle → sum=0, out_valid=0, busy=0, in_ready=1. After release, a=0x00F0, b=0x0010 → sum=0x0100.
- With SUBTRACT_EN: sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, c_out=0, ovf=0. Then sub=1, a=0x8000, b=0x0001 → sum=0x7FFF, c_out=1, ovf=1.

Source files
------------

// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - operand/result handshake bundle for nibble_serial_adder
// Optional macro: SUBTRACT_EN adds the sub request line.
// Signals:
//   in_valid/in_ready   operand handshake (a, b, c_in, sub)
//   out_valid/out_ready result handshake (sum, c_out, ovf)
//   busy                high while the adder is stepping nibbles
// Modports: master = upstream/downstream side, slave = the adder.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef SUBTRACT_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             busy;

  modport master (
`ifdef SUBTRACT_EN
    output sub,
`endif
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, busy
  );

  modport slave (
`ifdef SUBTRACT_EN
    input  sub,
`endif
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, busy
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle WIDTH-bit adder stepping one 4-bit CLA slice per clock
// Optional macro: SUBTRACT_EN (sub=1 at accept computes a-b).
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  nibble_serial_adder_if.slave: in_valid/in_ready/a/b/c_in[/sub],
//        out_valid/out_ready/sum/c_out/ovf, busy
// WIDTH must be a multiple of 4 and at least 4.

// 4-bit carry-lookahead slice.
module CLA_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign sum   = p ^ c[3:0];
  assign c_out = c[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_serial_adder_if.slave bus
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;     // already inverted for subtraction
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] sum_r;
  logic             c_out_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             busy_r;
  logic             out_valid_r;

  logic [IDXW+1:0]  nib_base;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       slice_sum;
  logic             slice_c_out;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign nib_base = {idx, 2'b00};
  assign a_nib    = op_a[nib_base +: 4];
  assign b_nib    = op_b[nib_base +: 4];

  CLA_4_bit u_slice (
    .a     (a_nib),
    .b     (b_nib),
    .c_in  (carry),
    .sum   (slice_sum),
    .c_out (slice_c_out)
  );

  // Subtraction is a + ~b + 1, so the slice never needs to know about it.
`ifdef SUBTRACT_EN
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c_eff = bus.sub ? 1'b1 : bus.c_in;
`else
  assign b_eff = bus.b;
  assign c_eff = bus.c_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      carry       <= 1'b0;
      idx         <= '0;
      sum_r       <= '0;
      c_out_r     <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready is high exactly in IDLE, so in_valid alone completes the handshake
          if (bus.in_valid) begin
            op_a       <= bus.a;
            op_b       <= b_eff;
            carry      <= c_eff;
            idx        <= '0;
            sum_r      <= '0;
            state      <= RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        RUN: begin
          sum_r[nib_base +: 4] <= slice_sum;
          carry                <= slice_c_out;
          idx                  <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            c_out_r     <= slice_c_out;
            // Same-sign operands with a result of the other sign overflowed.
            ovf_r       <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (slice_sum[3] != op_a[WIDTH-1]);
            state       <= DONE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.busy      = busy_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.c_out     = c_out_r;
  assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  nibble_serial_adder_if #(.WIDTH(W)) bus ();

  nibble_serial_adder #(.WIDTH(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction-level arithmetic plus fixed latency.
  bit             m_idle;
  int             m_wait;
  bit             m_done;
  logic [W-1:0]   exp_sum;
  bit             exp_c;
  bit             exp_ovf;

  task automatic model_compute(input logic [W-1:0] ta, input logic [W-1:0] tb_in,
                               input bit tc, input bit tsub);
    longint ua, ub, total, sa, sb, st;
    bit     cin;
    logic [W-1:0] beff;
    beff = tsub ? ~tb_in : tb_in;
    cin  = tsub ? 1'b1 : tc;
    ua = longint'(ta);
    ub = longint'(beff);
    total = ua + ub + longint'(cin);
    exp_sum = total[W-1:0];
    exp_c   = total[W];
    sa = longint'($signed(ta));
    sb = longint'($signed(beff));
    st = sa + sb + longint'(cin);
    exp_ovf = (st > (2 ** (W - 1)) - 1) || (st < -(2 ** (W - 1)));
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle = 1'b1;
      m_wait = 0;
      m_done = 1'b0;
    end else if (m_idle) begin
      if (bus.in_valid) begin
`ifdef SUBTRACT_EN
        model_compute(bus.a, bus.b, bus.c_in, bus.sub);
`else
        model_compute(bus.a, bus.b, bus.c_in, 1'b0);
`endif
        m_idle = 1'b0;
        m_wait = NIB;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_done = 1'b1;
    end else if (m_done && bus.out_ready) begin
      m_done = 1'b0;
      m_idle = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", bus.in_ready, m_idle);
      check("busy", bus.busy, (m_wait > 0));
      check("out_valid", bus.out_valid, m_done);
      if (m_done) begin
        check("sum", bus.sum, exp_sum);
        check("c_out", bus.c_out, exp_c);
        check("ovf", bus.ovf, exp_ovf);
      end
    end
  end

  task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb_in,
                        input bit tc, input bit tsub);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.a        = ta;
    bus.b        = tb_in;
    bus.c_in     = tc;
`ifdef SUBTRACT_EN
    bus.sub      = tsub;
`else
    if (tsub) check("sub_unsupported", 1, 0);
`endif
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) check("out_valid_timeout", 0, 1);
  endtask

  // Hold the result under backpressure while throwing junk operands at the block.
  task automatic release_result(input int hold);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      bus.c_in     = 1'($urandom_range(0, 1));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_in,
                          input bit tc, input bit tsub, input logic [W-1:0] lit_sum,
                          input bit lit_c, input bit lit_ovf);
    int lat;
    accept(ta, tb_in, tc, tsub);
    wait_result(lat);
    check({name, "_latency"}, lat, NIB);
    check({name, "_sum"}, bus.sum, lit_sum);
    check({name, "_c_out"}, bus.c_out, lit_c);
    check({name, "_ovf"}, bus.ovf, lit_ovf);
    check({name, "_model_sum"}, exp_sum, lit_sum);
    release_result(0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    n_checks = 0;
    n_fails  = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
    bus.out_ready = 1'b0;
`ifdef SUBTRACT_EN
    bus.sub       = 1'b0;
`endif
    #1;
    check("rst_sum", bus.sum, 0);
    check("rst_c_out", bus.c_out, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    directed("plain",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    directed("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("sovf",   16'h7FFF, 16'h0001, 1'b1, 1'b0, 16'h8001, 1'b0, 1'b1);

    // Backpressure: result must hold for 5 cycles while junk operands are offered.
    accept(16'h0A0A, 16'h0505, 1'b0, 1'b0);
    wait_result(lat);
    release_result(5);
    check("bp_in_ready_after", bus.in_ready, 1);
    directed("bp_next", 16'h1111, 16'h2222, 1'b1, 1'b0, 16'h3334, 1'b0, 1'b0);

    // Reset during the second RUN cycle.
    accept(16'hABCD, 16'h1234, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_sum", bus.sum, 0);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    directed("post_rst", 16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

`ifdef SUBTRACT_EN
    directed("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

    // Randomized operations with random backpressure, checked by the model.
    for (int n = 0; n < 60; n++) begin
      logic [W-1:0] ra, rb;
      bit rsub;
      ra = W'($urandom);
      rb = W'($urandom);
      if (n % 7 == 0) rb = ~ra;
`ifdef SUBTRACT_EN
      rsub = bit'($urandom_range(0, 1));
`else
      rsub = 1'b0;
`endif
      accept(ra, rb, 1'($urandom_range(0, 1)), rsub);
      wait_result(lat);
      release_result(int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
